// File: rtl/world_clock_pkg.sv
// Shared time types and constants for the world-clock datapath.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package world_clock_pkg;

    typedef logic [4:0]        hour_t;
    typedef logic [5:0]        min_t;
    typedef logic signed [11:0] ofs_t;

    localparam int HOURS_PER_DAY = 24;
    localparam int MINS_PER_HOUR = 60;
    localparam int MINS_PER_DAY  = 1440;

    // One correction is enough for any base time plus a legal offset.
    function automatic int wrap_day(input int t);
        if (t < 0) begin
            return t + MINS_PER_DAY;
        end
        if (t >= MINS_PER_DAY) begin
            return t - MINS_PER_DAY;
        end
        return t;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge step generator with optional hold-to-repeat for one debounced button.
// Latency: step is combinational from btn in the cycle the button is sampled.
// Backpressure: none; a button held across reset release is ignored until re-pressed.
module btn_repeat #(
    parameter int DELAY     = 50,
    parameter int RATE      = 10,
    parameter int REPEAT_EN = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic step
);

    localparam int TOP = DELAY + RATE;
    localparam int CW  = $clog2(TOP + 1);

    logic          prev;
    logic          armed;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          rep;

    // cnt holds the number of cycles since the press edge; it cycles
    // DELAY+1..TOP once repeating so it never needs to grow further.
    assign rise = btn & ~prev;
    assign rep  = (REPEAT_EN != 0) && armed && btn && prev &&
                  ((cnt == CW'(DELAY)) || (cnt == CW'(TOP)));
    assign step = rise | rep;

    always_ff @(posedge clock) begin
        prev <= btn;
        if (reset) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (rise) begin
            armed <= 1'b1;
            cnt   <= CW'(1);
        end else if (!btn) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (armed) begin
            if (cnt == CW'(TOP)) begin
                cnt <= CW'(DELAY + 1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/multi_zone_time_set.sv
// Base-time setter with minute/hour buttons and per-zone offset conversion.
// Latency: base 1 cycle after a sampled step, zone outputs 1 cycle after base/zone_sel.
// Backpressure: none; steps are applied every cycle they occur.
module multi_zone_time_set
    import world_clock_pkg::*;
#(
    parameter int                    N_ZONES      = 4,
    parameter logic [12*N_ZONES-1:0] ZONE_OFS_MIN = {12'sd0, 12'sd330, -12'sd180, 12'sd300},
    parameter int                    REPEAT_DELAY = 50,
    parameter int                    REPEAT_RATE  = 10,
    parameter int                    CARRY_EN     = 1,
    localparam int                   ZW           = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          hour_inc,
    input  logic          min_inc,
    input  logic          dec,
    input  logic          zone_next,
    output logic [4:0]    base_hours,
    output logic [5:0]    base_mins,
    output logic [ZW-1:0] zone_sel,
    output logic [4:0]    zone_hours,
    output logic [5:0]    zone_mins
);

    logic  hour_step;
    logic  min_step;
    logic  zone_step;
    min_t  mins_nxt;
    hour_t hours_nxt;
    int    carry;
    int    hour_sum;
    ofs_t  zone_ofs;
    hour_t conv_h;
    min_t  conv_m;
    ofs_t  conv_ofs;
    int    day_min;
    int    zh_i;

    btn_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE), .REPEAT_EN(1)) u_hour_btn (
        .clock(clock), .reset(reset), .btn(hour_inc), .step(hour_step)
    );
    btn_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE), .REPEAT_EN(1)) u_min_btn (
        .clock(clock), .reset(reset), .btn(min_inc), .step(min_step)
    );
    btn_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE), .REPEAT_EN(0)) u_zone_btn (
        .clock(clock), .reset(reset), .btn(zone_next), .step(zone_step)
    );

    // Minute carry and hour step are summed so both land in one update.
    always_comb begin
        mins_nxt = base_mins;
        carry    = 0;
        if (min_step) begin
            if (dec) begin
                if (base_mins == '0) begin
                    mins_nxt = min_t'(MINS_PER_HOUR - 1);
                    carry    = -1;
                end else begin
                    mins_nxt = base_mins - 6'd1;
                end
            end else begin
                if (base_mins == min_t'(MINS_PER_HOUR - 1)) begin
                    mins_nxt = '0;
                    carry    = 1;
                end else begin
                    mins_nxt = base_mins + 6'd1;
                end
            end
        end
        if (CARRY_EN == 0) begin
            carry = 0;
        end
        hour_sum = int'(base_hours) + carry;
        if (hour_step) begin
            hour_sum = dec ? hour_sum - 1 : hour_sum + 1;
        end
        if (hour_sum < 0) begin
            hour_sum = hour_sum + HOURS_PER_DAY;
        end else if (hour_sum >= HOURS_PER_DAY) begin
            hour_sum = hour_sum - HOURS_PER_DAY;
        end
        hours_nxt = hour_t'(hour_sum);
    end

    always_comb begin
        zone_ofs = $signed(ZONE_OFS_MIN[11:0]);
        for (int i = 0; i < N_ZONES; i++) begin
            if (zone_sel == ZW'(i)) begin
                zone_ofs = $signed(ZONE_OFS_MIN[12*i +: 12]);
            end
        end
    end

    // While in reset the conversion sees 00:00 in zone 0, so the zone
    // outputs are already valid on the first cycle after release.
    always_comb begin
        conv_h   = reset ? '0 : base_hours;
        conv_m   = reset ? '0 : base_mins;
        conv_ofs = reset ? $signed(ZONE_OFS_MIN[11:0]) : zone_ofs;
        day_min  = wrap_day(int'(conv_h) * MINS_PER_HOUR + int'(conv_m) + int'(conv_ofs));
        zh_i     = 0;
        for (int h = 1; h < HOURS_PER_DAY; h++) begin
            if (day_min >= h * MINS_PER_HOUR) begin
                zh_i = h;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base_hours <= '0;
            base_mins  <= '0;
            zone_sel   <= '0;
        end else begin
            base_hours <= hours_nxt;
            base_mins  <= mins_nxt;
            if (zone_step) begin
                zone_sel <= (zone_sel == ZW'(N_ZONES - 1)) ? '0 : zone_sel + ZW'(1);
            end
        end
        zone_hours <= hour_t'(zh_i);
        zone_mins  <= min_t'(day_min - zh_i * MINS_PER_HOUR);
    end

endmodule

// File: tb/tb_multi_zone_time_set.sv
// Directed bench: two instances (minute carry on and off) share all inputs.
module tb_multi_zone_time_set;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       hour_inc = 1'b0;
    logic       min_inc = 1'b0;
    logic       dec = 1'b0;
    logic       zone_next = 1'b0;
    logic [4:0] bh, zh, nbh, nzh;
    logic [5:0] bm, zm, nbm, nzm;
    logic [1:0] zs, nzs;
    int         n_checks = 0;
    int         n_errors = 0;

    localparam int B_HOUR = 0;
    localparam int B_MIN  = 1;
    localparam int B_ZONE = 2;
    localparam int B_BOTH = 3;

    always #5 clock = ~clock;

    multi_zone_time_set #(.CARRY_EN(1)) dut (
        .clock(clock), .reset(reset), .hour_inc(hour_inc), .min_inc(min_inc),
        .dec(dec), .zone_next(zone_next), .base_hours(bh), .base_mins(bm),
        .zone_sel(zs), .zone_hours(zh), .zone_mins(zm)
    );

    multi_zone_time_set #(.CARRY_EN(0)) dut_nc (
        .clock(clock), .reset(reset), .hour_inc(hour_inc), .min_inc(min_inc),
        .dec(dec), .zone_next(zone_next), .base_hours(nbh), .base_mins(nbm),
        .zone_sel(nzs), .zone_hours(nzh), .zone_mins(nzm)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int tm(input logic [4:0] h, input logic [5:0] m);
        return int'(h) * 100 + int'(m);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One-cycle press plus one idle cycle, so base and zone have both settled on return.
    task automatic press(input int b);
        case (b)
            B_HOUR:  hour_inc = 1'b1;
            B_MIN:   min_inc = 1'b1;
            B_ZONE:  zone_next = 1'b1;
            default: begin
                hour_inc = 1'b1;
                min_inc  = 1'b1;
            end
        endcase
        @(negedge clock);
        hour_inc  = 1'b0;
        min_inc   = 1'b0;
        zone_next = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("first_zone", tm(zh, zm), 500);
        cyc(2);
        check("rst_base", tm(bh, bm), 0);
        check("rst_sel", int'(zs), 0);
        check("rst_zone", tm(zh, zm), 500);

        press(B_ZONE);
        press(B_ZONE);
        check("sel2", int'(zs), 2);
        check("zone2", tm(zh, zm), 530);
        press(B_ZONE);
        check("sel3", int'(zs), 3);
        check("zone3", tm(zh, zm), 0);
        press(B_ZONE);
        check("sel_wrap", int'(zs), 0);
        check("zone0", tm(zh, zm), 500);

        dec = 1'b1;
        press(B_MIN);
        check("dec_borrow", tm(bh, bm), 2359);
        check("nc_dec_wrap", tm(nbh, nbm), 59);
        press(B_BOTH);
        check("dec_both", tm(bh, bm), 2258);
        check("nc_dec_both", tm(nbh, nbm), 2358);
        dec = 1'b0;
        press(B_MIN);
        press(B_MIN);
        check("carry_2259", tm(bh, bm), 2300);
        check("nc_wrap", tm(nbh, nbm), 2300);
        dec = 1'b1;
        press(B_MIN);
        dec = 1'b0;
        press(B_HOUR);
        check("pre_carry", tm(bh, bm), 2359);
        press(B_MIN);
        check("carry_day", tm(bh, bm), 0);
        check("nc_0059", tm(nbh, nbm), 0);

        press(B_ZONE);
        press(B_HOUR);
        for (int i = 0; i < 30; i++) press(B_MIN);
        check("base_0130", tm(bh, bm), 130);
        check("sel1", int'(zs), 1);
        check("zone_neg", tm(zh, zm), 2230);
        press(B_ZONE);
        dec = 1'b1;
        for (int i = 0; i < 5; i++) press(B_HOUR);
        dec = 1'b0;
        for (int i = 0; i < 14; i++) press(B_MIN);
        check("zone_2044", tm(zh, zm), 214);
        min_inc = 1'b1;
        @(negedge clock);
        min_inc = 1'b0;
        check("base_2045", tm(bh, bm), 2045);
        check("zone_lag", tm(zh, zm), 214);
        cyc(1);
        check("zone_pos", tm(zh, zm), 215);

        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        hour_inc = 1'b1;
        cyc(81);
        hour_inc = 1'b0;
        cyc(2);
        check("hold81", tm(bh, bm), 500);

        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        hour_inc = 1'b1;
        cyc(55);
        check("hold55", tm(bh, bm), 200);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(100);
        check("rst_hold", tm(bh, bm), 0);
        check("rst_hold_zone", tm(zh, zm), 500);
        hour_inc = 1'b0;
        cyc(2);
        press(B_HOUR);
        check("repress", tm(bh, bm), 100);

        zone_next = 1'b1;
        cyc(200);
        zone_next = 1'b0;
        cyc(2);
        check("zone_hold", int'(zs), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
